// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Game-control front end. Accumulates ball-pop points into a
//             saturating score, tracks player lives with a post-hit grace
//             period, and generates the one-second tick (secClk) and the
//             game-over flag consumed by the level state machine.
//  Options  : SCORE_COMBO_EN - when defined, hits landing within one tick
//             window earn a combo bonus (0..3) on top of the base points.
//  Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter int SEC_DIV    = 25000000,
  parameter int PTS_SMALL  = 1,
  parameter int PTS_MEDIUM = 2,
  parameter int PTS_BIG    = 3,
  parameter int PTS_HUGE   = 5,
  parameter int SCORE_MAX  = 9999,
  parameter int LIVES_INIT = 3,
  parameter int INVULN_SEC = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              enable,
  input  logic              hitValid,
  input  logic [1:0]        hitSize,
  input  logic              playerHit,
  output logic signed [15:0] score,
  output logic              secClk,
  output logic [2:0]        lives,
  output logic              invuln,
  output logic              gameOver
);

  localparam int DIV_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int INV_W = (INVULN_SEC > 0) ? $clog2(INVULN_SEC + 1) : 1;

  localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(SEC_DIV - 1);
  localparam logic [INV_W-1:0] C_INV_LOAD   = INV_W'(INVULN_SEC);
  localparam logic [2:0]       C_LIVES_INIT = 3'(LIVES_INIT);
  localparam logic [16:0]      C_SMAX17     = 17'(SCORE_MAX);
  localparam logic [15:0]      C_SMAX16     = 16'(SCORE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_INVULN = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic [15:0]        r_score, w_score;
  logic               r_sec, w_sec;
  logic [2:0]         r_lives, w_lives;
  logic               r_invuln, w_invuln;
  logic               r_gover, w_gover;
  logic [DIV_W-1:0]   r_div, w_div;
  logic [INV_W-1:0]   r_icnt, w_icnt;

  logic [7:0]         w_base;
  logic [7:0]         w_pts;
  logic [16:0]        w_sum;
  logic [15:0]        w_sat;

  // Map the popped ball size to its base point value.
  always_comb begin
    w_base = 8'(PTS_SMALL);
    case (hitSize)
      2'd0:    w_base = 8'(PTS_SMALL);
      2'd1:    w_base = 8'(PTS_MEDIUM);
      2'd2:    w_base = 8'(PTS_BIG);
      default: w_base = 8'(PTS_HUGE);
    endcase
  end

`ifdef SCORE_COMBO_EN
  logic [1:0] r_combo, w_combo;

  // A hit coinciding with the visible tick starts a fresh window (combo 0).
  assign w_pts = w_base + (r_sec ? 8'd0 : {6'd0, r_combo});
`else
  assign w_pts = w_base;
`endif

  // One extra bit of headroom so the saturation compare cannot wrap.
  assign w_sum = {1'b0, r_score} + {9'd0, w_pts};
  assign w_sat = (w_sum > C_SMAX17) ? C_SMAX16 : w_sum[15:0];

  // Next-state and next-output logic; every target defaults to hold.
  always_comb begin
    w_state  = r_state;
    w_score  = r_score;
    w_sec    = 1'b0;
    w_lives  = r_lives;
    w_invuln = r_invuln;
    w_gover  = r_gover;
    w_div    = r_div;
    w_icnt   = r_icnt;
`ifdef SCORE_COMBO_EN
    w_combo  = r_combo;
`endif
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state  = S_PLAY;
          w_lives  = C_LIVES_INIT;
          w_score  = 16'd0;
          w_gover  = 1'b0;
          w_invuln = 1'b0;
          w_div    = '0;
          w_icnt   = '0;
`ifdef SCORE_COMBO_EN
          w_combo  = 2'd0;
`endif
        end
      end

      S_PLAY, S_INVULN: begin
        if (!enable) begin
          // Leaving play drops any pending hit and the grace flag.
          w_state  = S_IDLE;
          w_invuln = 1'b0;
        end else begin
          // Divider runs continuously across PLAY <-> INVULN.
          if (r_div == C_DIV_LAST) begin
            w_div = '0;
            w_sec = 1'b1;
          end else begin
            w_div = r_div + 1'b1;
          end

          if (hitValid) begin
            w_score = w_sat;
          end

`ifdef SCORE_COMBO_EN
          if (r_sec) begin
            w_combo = hitValid ? 2'd1 : 2'd0;
          end else if (hitValid && (r_combo != 2'd3)) begin
            w_combo = r_combo + 2'd1;
          end
`endif

          if (r_state == S_PLAY) begin
            if (playerHit) begin
              if (r_lives > 3'd1) begin
                w_state  = S_INVULN;
                w_lives  = r_lives - 3'd1;
                w_invuln = 1'b1;
                w_icnt   = C_INV_LOAD;
              end else begin
                // Last life: points above still count, tick is suppressed.
                w_state  = S_OVER;
                w_lives  = 3'd0;
                w_gover  = 1'b1;
                w_sec    = 1'b0;
              end
            end
          end else begin
            // Grace period consumes visible tick pulses; playerHit ignored.
            if (r_sec) begin
              if (r_icnt <= INV_W'(1)) begin
                w_icnt   = '0;
                w_invuln = 1'b0;
                w_state  = S_PLAY;
              end else begin
                w_icnt = r_icnt - 1'b1;
              end
            end
          end
        end
      end

      default: begin
        // OVER: everything frozen until play mode is released.
        if (!enable) begin
          w_state = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers with synchronous active-high clear.
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state  <= S_IDLE;
      r_score  <= 16'd0;
      r_sec    <= 1'b0;
      r_lives  <= 3'd0;
      r_invuln <= 1'b0;
      r_gover  <= 1'b0;
      r_div    <= '0;
      r_icnt   <= '0;
`ifdef SCORE_COMBO_EN
      r_combo  <= 2'd0;
`endif
    end else begin
      r_state  <= w_state;
      r_score  <= w_score;
      r_sec    <= w_sec;
      r_lives  <= w_lives;
      r_invuln <= w_invuln;
      r_gover  <= w_gover;
      r_div    <= w_div;
      r_icnt   <= w_icnt;
`ifdef SCORE_COMBO_EN
      r_combo  <= w_combo;
`endif
    end
  end

  assign score    = $signed(r_score);
  assign secClk   = r_sec;
  assign lives    = r_lives;
  assign invuln   = r_invuln;
  assign gameOver = r_gover;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Self-checking bench for score_keeper with a behavioural model
//             kept in plain integers (elapsed active cycles, ticks remaining,
//             saturating arithmetic). Honours SCORE_COMBO_EN if defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

  localparam int SEC_DIV    = 10;
  localparam int SCORE_MAX  = 9999;
  localparam int LIVES_INIT = 3;
  localparam int INVULN_SEC = 2;

  localparam int M_IDLE = 0, M_PLAY = 1, M_INVULN = 2, M_OVER = 3;

  logic clk = 1'b0;
  logic resetN, enable, hitValid, playerHit;
  logic [1:0] hitSize;
  logic signed [15:0] score;
  logic secClk, invuln, gameOver;
  logic [2:0] lives;
  logic [21:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_st, m_score, m_lives, m_sec, m_inv, m_go, m_phase, m_grace, m_combo;

  score_keeper #(
    .SEC_DIV(SEC_DIV), .PTS_SMALL(1), .PTS_MEDIUM(2), .PTS_BIG(3), .PTS_HUGE(5),
    .SCORE_MAX(SCORE_MAX), .LIVES_INIT(LIVES_INIT), .INVULN_SEC(INVULN_SEC)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .hitValid(hitValid),
    .hitSize(hitSize), .playerHit(playerHit), .score(score), .secClk(secClk),
    .lives(lives), .invuln(invuln), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  assign dut_vec = {score, secClk, lives, invuln, gameOver};

  function automatic int base_pts(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 3;
      default: return 5;
    endcase
  endfunction

  function automatic logic [21:0] exp_vec();
    return {16'(m_score), 1'(m_sec), 3'(m_lives), 1'(m_inv), 1'(m_go)};
  endfunction

  function automatic logic [1:0] size_for(input int remaining);
    if (remaining >= 5) return 2'd3;
    if (remaining >= 3) return 2'd2;
    if (remaining >= 2) return 2'd1;
    return 2'd0;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int pulse;
    int bonus;
    if (resetN) begin
      m_st = M_IDLE; m_score = 0; m_lives = 0; m_sec = 0; m_inv = 0;
      m_go = 0; m_phase = 0; m_grace = 0; m_combo = 0;
      return;
    end
    pulse = m_sec;
    case (m_st)
      M_IDLE: begin
        m_sec = 0;
        if (enable) begin
          m_st = M_PLAY; m_lives = LIVES_INIT; m_score = 0; m_go = 0;
          m_phase = 0; m_inv = 0; m_grace = 0; m_combo = 0;
        end
      end
      M_OVER: begin
        m_sec = 0;
        if (!enable) m_st = M_IDLE;
      end
      default: begin
        if (!enable) begin
          m_st = M_IDLE; m_sec = 0; m_inv = 0;
        end else begin
          bonus = 0;
`ifdef SCORE_COMBO_EN
          bonus = pulse ? 0 : m_combo;
          if (pulse) m_combo = hitValid ? 1 : 0;
          else if (hitValid && m_combo < 3) m_combo++;
`endif
          if (hitValid) begin
            m_score = m_score + base_pts(hitSize) + bonus;
            if (m_score > SCORE_MAX) m_score = SCORE_MAX;
          end
          m_phase++;
          m_sec = ((m_phase % SEC_DIV) == 0) ? 1 : 0;
          if (m_st == M_PLAY && playerHit) begin
            if (m_lives > 1) begin
              m_lives--; m_inv = 1; m_grace = INVULN_SEC; m_st = M_INVULN;
            end else begin
              m_lives = 0; m_go = 1; m_st = M_OVER; m_sec = 0;
            end
          end else if (m_st == M_INVULN && pulse) begin
            m_grace--;
            if (m_grace == 0) begin
              m_inv = 0; m_st = M_PLAY;
            end
          end
        end
      end
    endcase
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Step until the DUT grace period ends; counts visible ticks during it.
  task automatic wait_grace(output int pulses, output bit timed_out);
    pulses = 0;
    for (int i = 0; i < 200 && invuln === 1'b1; i++) begin
      step();
      if (secClk === 1'b1) pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL grace_cycle got %h want %h", dut_vec, exp_vec());
      end
    end
    timed_out = (invuln === 1'b1);
  endtask

  task automatic test_reset();
    resetN = 1'b1; enable = 1'b0; hitValid = 1'b0; hitSize = 2'd0; playerHit = 1'b0;
    step(); step();
    checks++;
    if (dut_vec !== 22'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", dut_vec);
    end
    resetN = 1'b0;
    step();
    checks++;
    if (lives !== 3'd0 || secClk !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got lives=%0d sec=%0d want 0 0", lives, secClk);
    end
  endtask

  task automatic test_start();
    enable = 1'b1;
    step();
    checks++;
    if (lives !== 3'd3 || score !== 16'sd0 || gameOver !== 1'b0) begin
      errors++;
      $display("FAIL start_load got lives=%0d score=%0d go=%0d want 3 0 0", lives, score, gameOver);
    end
    for (int i = 1; i <= 25; i++) begin
      step();
      checks++;
      if (secClk !== ((i % SEC_DIV) == 0)) begin
        errors++; $display("FAIL tick_period cycle %0d got %0d want %0d", i, secClk, (i % SEC_DIV) == 0);
      end
    end
  endtask

  task automatic test_scoring();
    int tbl[4];
    int guard;
    tbl = '{1, 3, 6, 11};
    for (int k = 0; k < 4; k++) begin
      hitValid = 1'b1; hitSize = 2'(k);
      step();
      hitValid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL score_size%0d got %h want %h", k, dut_vec, exp_vec());
      end
`ifndef SCORE_COMBO_EN
      checks++;
      if (score !== 16'(tbl[k])) begin
        errors++; $display("FAIL score_seq%0d got %0d want %0d", k, score, tbl[k]);
      end
`endif
      step();
    end
    guard = 0;
    while (m_score < SCORE_MAX - 1 && guard < 5000) begin
      hitValid = 1'b1; hitSize = size_for(SCORE_MAX - 1 - m_score);
      step();
      guard++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL score_pump got %h want %h", dut_vec, exp_vec());
      end
    end
    hitValid = 1'b0;
    checks++;
    if (guard >= 5000) begin
      errors++; $display("FAIL score_pump_timeout got %0d want %0d", m_score, SCORE_MAX - 1);
    end
`ifndef SCORE_COMBO_EN
    checks++;
    if (score !== 16'sd9998) begin
      errors++; $display("FAIL score_9998 got %0d want 9998", score);
    end
`endif
    hitValid = 1'b1; hitSize = 2'd3;
    step();
    hitValid = 1'b0;
    checks++;
    if (score !== 16'sd9999) begin
      errors++; $display("FAIL score_saturate got %0d want 9999", score);
    end
  endtask

  task automatic test_lives();
    int pulses;
    bit tmo;
    playerHit = 1'b1; step(); playerHit = 1'b0;
    checks++;
    if (lives !== 3'd2 || invuln !== 1'b1) begin
      errors++; $display("FAIL first_hit got lives=%0d inv=%0d want 2 1", lives, invuln);
    end
    step(); step();
    playerHit = 1'b1; step(); playerHit = 1'b0;
    checks++;
    if (lives !== 3'd2) begin
      errors++; $display("FAIL hit_in_grace got lives=%0d want 2", lives);
    end
    wait_grace(pulses, tmo);
    checks++;
    if (tmo || pulses != INVULN_SEC) begin
      errors++; $display("FAIL grace_len got pulses=%0d tmo=%0d want %0d 0", pulses, tmo, INVULN_SEC);
    end
    step();
    playerHit = 1'b1; step(); playerHit = 1'b0;
    checks++;
    if (lives !== 3'd1 || invuln !== 1'b1) begin
      errors++; $display("FAIL second_hit got lives=%0d inv=%0d want 1 1", lives, invuln);
    end
    wait_grace(pulses, tmo);
    checks++;
    if (tmo) begin
      errors++; $display("FAIL grace2_timeout got inv=%0d want 0", invuln);
    end
    step();
    playerHit = 1'b1; step(); playerHit = 1'b0;
    checks++;
    if (lives !== 3'd0 || gameOver !== 1'b1 || invuln !== 1'b0) begin
      errors++; $display("FAIL last_hit got lives=%0d go=%0d inv=%0d want 0 1 0", lives, gameOver, invuln);
    end
    for (int i = 0; i < 25; i++) begin
      hitValid = (i == 3); hitSize = 2'd3;
      step();
      checks++;
      if (secClk !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL over_hold got %h want %h", dut_vec, exp_vec());
      end
    end
    hitValid = 1'b0;
  endtask

  task automatic test_restart();
    enable = 1'b0; step();
    checks++;
    if (dut_vec !== exp_vec() || secClk !== 1'b0) begin
      errors++; $display("FAIL idle_hold got %h want %h", dut_vec, exp_vec());
    end
    enable = 1'b1; step();
    checks++;
    if (lives !== 3'd3 || score !== 16'sd0 || gameOver !== 1'b0) begin
      errors++;
      $display("FAIL restart_load got lives=%0d score=%0d go=%0d want 3 0 0", lives, score, gameOver);
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    bit tmo;
    int prev;
    playerHit = 1'b1; step(); playerHit = 1'b0;
    wait_grace(pulses, tmo);
    step();
    playerHit = 1'b1; step(); playerHit = 1'b0;
    wait_grace(pulses, tmo);
    step();
    checks++;
    if (lives !== 3'd1 || tmo) begin
      errors++; $display("FAIL sim_setup got lives=%0d want 1", lives);
    end
    prev = m_score;
    hitValid = 1'b1; hitSize = 2'd2; playerHit = 1'b1;
    step();
    hitValid = 1'b0; playerHit = 1'b0;
    checks++;
    if (score !== 16'(prev + 3) || lives !== 3'd0 || gameOver !== 1'b1) begin
      errors++;
      $display("FAIL sim_hit got score=%0d lives=%0d go=%0d want %0d 0 1", score, lives, gameOver, prev + 3);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (m_score < 42 && guard < 100) begin
      hitValid = 1'b1; hitSize = size_for(42 - m_score);
      step();
      hitValid = 1'b0;
      guard++;
    end
`ifndef SCORE_COMBO_EN
    checks++;
    if (score !== 16'sd42) begin
      errors++; $display("FAIL mid_score got %0d want 42", score);
    end
`endif
    playerHit = 1'b1; step(); playerHit = 1'b0;
    checks++;
    if (invuln !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL mid_invuln got %h want %h", dut_vec, exp_vec());
    end
    resetN = 1'b1; step(); resetN = 1'b0;
    checks++;
    if (dut_vec !== 22'd0) begin
      errors++; $display("FAIL mid_reset got %h want 0", dut_vec);
    end
    step();
    checks++;
    if (lives !== 3'd3 || score !== 16'sd0) begin
      errors++; $display("FAIL mid_reload got lives=%0d score=%0d want 3 0", lives, score);
    end
  endtask

`ifdef SCORE_COMBO_EN
  task automatic test_combo();
    int tbl[3];
    int guard;
    tbl = '{1, 3, 6};
    enable = 1'b0; step(); enable = 1'b1; step();
    for (int k = 0; k < 3; k++) begin
      hitValid = 1'b1; hitSize = 2'd0; step(); hitValid = 1'b0;
      checks++;
      if (score !== 16'(tbl[k])) begin
        errors++; $display("FAIL combo_seq%0d got %0d want %0d", k, score, tbl[k]);
      end
    end
    guard = 0;
    while (secClk !== 1'b1 && guard < 50) begin step(); guard++; end
    step(); step();
    hitValid = 1'b1; hitSize = 2'd0; step(); hitValid = 1'b0;
    checks++;
    if (score !== 16'sd7) begin
      errors++; $display("FAIL combo_after_tick got %0d want 7", score);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      resetN    = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 59) != 0);
      hitValid  = $urandom_range(0, 1) == 1;
      hitSize   = 2'($urandom_range(0, 3));
      playerHit = ($urandom_range(0, 24) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    resetN = 1'b0; hitValid = 1'b0; playerHit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_scoring();
    test_lives();
    test_restart();
    test_simultaneous();
    test_restart();
    test_reset_mid();
`ifdef SCORE_COMBO_EN
    test_combo();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
